// File: rtl/ps2_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard scan-code decoder.
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_E0,
      ST_F0,
      ST_E0F0
   } kbd_state_t;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef struct packed {
      logic [7:0] code;
      logic [7:0] ascii;
      logic       ext;
      logic       brk;
   } kbd_event_t;

   // Odd parity over code+parity bit, and the stop bit must be high.
   function automatic logic frame_ok(input logic [9:0] frame);
      return (^frame[8:0]) & frame[9];
   endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational scan-code set 2 to ASCII translation for letters, digits, space, enter, backspace.
module ps2_ascii_lut (
   input  logic [7:0] code,
   input  logic       shift,
   input  logic       caps,
   output logic [7:0] ascii
);

   logic [7:0] lower;
   logic       letter;

   always_comb begin
      lower  = 8'h00;
      letter = 1'b0;
      ascii  = 8'h00;
      case (code)
         8'h1C: begin lower = "a"; letter = 1'b1; end
         8'h32: begin lower = "b"; letter = 1'b1; end
         8'h21: begin lower = "c"; letter = 1'b1; end
         8'h23: begin lower = "d"; letter = 1'b1; end
         8'h24: begin lower = "e"; letter = 1'b1; end
         8'h2B: begin lower = "f"; letter = 1'b1; end
         8'h34: begin lower = "g"; letter = 1'b1; end
         8'h33: begin lower = "h"; letter = 1'b1; end
         8'h43: begin lower = "i"; letter = 1'b1; end
         8'h3B: begin lower = "j"; letter = 1'b1; end
         8'h42: begin lower = "k"; letter = 1'b1; end
         8'h4B: begin lower = "l"; letter = 1'b1; end
         8'h3A: begin lower = "m"; letter = 1'b1; end
         8'h31: begin lower = "n"; letter = 1'b1; end
         8'h44: begin lower = "o"; letter = 1'b1; end
         8'h4D: begin lower = "p"; letter = 1'b1; end
         8'h15: begin lower = "q"; letter = 1'b1; end
         8'h2D: begin lower = "r"; letter = 1'b1; end
         8'h1B: begin lower = "s"; letter = 1'b1; end
         8'h2C: begin lower = "t"; letter = 1'b1; end
         8'h3C: begin lower = "u"; letter = 1'b1; end
         8'h2A: begin lower = "v"; letter = 1'b1; end
         8'h1D: begin lower = "w"; letter = 1'b1; end
         8'h22: begin lower = "x"; letter = 1'b1; end
         8'h35: begin lower = "y"; letter = 1'b1; end
         8'h1A: begin lower = "z"; letter = 1'b1; end
         8'h16: ascii = shift ? "!" : "1";
         8'h1E: ascii = shift ? "@" : "2";
         8'h26: ascii = shift ? "#" : "3";
         8'h25: ascii = shift ? "$" : "4";
         8'h2E: ascii = shift ? "%" : "5";
         8'h36: ascii = shift ? "^" : "6";
         8'h3D: ascii = shift ? "&" : "7";
         8'h3E: ascii = shift ? "*" : "8";
         8'h46: ascii = shift ? "(" : "9";
         8'h45: ascii = shift ? ")" : "0";
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         8'h66: ascii = 8'h08;
         default: ascii = 8'h00;
      endcase
      if (letter) begin
         ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 frame checker, E0/F0 prefix tracker, modifier latch and key-event FIFO.
// Build option KBD_BREAK_EVENTS_EN: also queue key releases with out_brk=1.
module ps2_scancode_decoder
   import ps2_kbd_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_done,
   input  logic [9:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_code,
   output logic [7:0] out_ascii,
   output logic       out_ext,
   output logic       out_brk,
   output logic       shift_o,
   output logic       caps_o,
   output logic       err_frame,
   output logic       overflow
);

`ifdef KBD_BREAK_EVENTS_EN
   localparam logic BRK_EN = 1'b1;
`else
   localparam logic BRK_EN = 1'b0;
`endif

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic       done_d;
   logic       rise;
   logic [9:0] data_p1;
   logic       vld_p1;
   logic [7:0] code_p1;
   logic       good_p1;

   kbd_state_t state, state_nxt;
   logic       evt;
   logic       evt_ext;
   logic       evt_brk;

   logic       lshift_held, rshift_held, caps_held;
   logic [7:0] lut_ascii;
   kbd_event_t evt_word;
   kbd_event_t head;

   logic [PTR_W:0] wr_ptr, rd_ptr;
   kbd_event_t     mem [FIFO_DEPTH];
   logic           empty, full, pop, push_req, push;

   assign rise = in_done & ~done_d;

   // Stage 0 -> 1: capture the frame on the rising edge of done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_d <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         done_d <= in_done;
         vld_p1 <= rise;
      end
   end

   always_ff @(posedge clk) begin
      if (rise) data_p1 <= in_data;
   end

   assign code_p1   = data_p1[7:0];
   assign good_p1   = frame_ok(data_p1);
   assign err_frame = vld_p1 & ~good_p1;

   // Stage 1: prefix tracking and event completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      evt       = 1'b0;
      evt_ext   = (state == ST_E0) || (state == ST_E0F0);
      evt_brk   = (state == ST_F0) || (state == ST_E0F0);
      if (vld_p1) begin
         if (!good_p1) begin
            state_nxt = ST_IDLE;
         end else if (code_p1 == SC_EXT) begin
            state_nxt = ST_E0;
         end else if (code_p1 == SC_BRK) begin
            state_nxt = evt_ext ? ST_E0F0 : ST_F0;
         end else begin
            evt       = 1'b1;
            state_nxt = ST_IDLE;
         end
      end
   end

   // Caps toggles only on the first make, so typematic repeats are ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lshift_held <= 1'b0;
         rshift_held <= 1'b0;
         caps_held   <= 1'b0;
         caps_o      <= 1'b0;
      end else if (evt && !evt_ext) begin
         if (code_p1 == SC_LSHIFT) lshift_held <= ~evt_brk;
         if (code_p1 == SC_RSHIFT) rshift_held <= ~evt_brk;
         if (code_p1 == SC_CAPS) begin
            if (evt_brk) begin
               caps_held <= 1'b0;
            end else begin
               if (!caps_held) caps_o <= ~caps_o;
               caps_held <= 1'b1;
            end
         end
      end
   end

   assign shift_o = lshift_held | rshift_held;

   ps2_ascii_lut u_lut (
      .code  (code_p1),
      .shift (shift_o),
      .caps  (caps_o),
      .ascii (lut_ascii)
   );

   always_comb begin
      evt_word.code  = code_p1;
      evt_word.ascii = evt_ext ? 8'h00 : lut_ascii;
      evt_word.ext   = evt_ext;
      evt_word.brk   = evt_brk;
   end

   // Stage 1 -> 2: event FIFO, extra pointer bit separates full from empty
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign push_req  = evt & (BRK_EN | ~evt_brk);
   assign push      = push_req & (~full | pop);
   assign overflow  = push_req & full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= evt_word;
   end

   assign head      = mem[rd_ptr[PTR_W-1:0]];
   assign out_code  = out_valid ? head.code  : 8'h00;
   assign out_ascii = out_valid ? head.ascii : 8'h00;
   assign out_ext   = out_valid & head.ext;
   assign out_brk   = out_valid & head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued at stimulus, compared on pop.
module tb_ps2_scancode_decoder;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_done;
   logic [9:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic [7:0] out_ascii;
   logic       out_ext;
   logic       out_brk;
   logic       shift_o;
   logic       caps_o;
   logic       err_frame;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;
   int err_cnt  = 0;
   int ovf_cnt  = 0;
   int base;

   logic [17:0] sb_q[$];

   always #5 clk = ~clk;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_done   (in_done),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_ascii (out_ascii),
      .out_ext   (out_ext),
      .out_brk   (out_brk),
      .shift_o   (shift_o),
      .caps_o    (caps_o),
      .err_frame (err_frame),
      .overflow  (overflow)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_evt(input logic [7:0] code, input logic [7:0] ascii,
                          input logic ext, input logic brk);
      sb_q.push_back({code, ascii, ext, brk});
   endtask

   // Returns in the cycle after the capturing edge (cycle 1).
   task automatic send(input logic [9:0] frame, input int hold = 1);
      @(posedge clk); #1;
      in_data = frame;
      in_done = 1'b1;
      repeat (hold) @(posedge clk);
      #1 in_done = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (DEPTH * 2 + 6) @(posedge clk);
      #1 check_val("sb_left", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (err_frame) err_cnt++;
      if (overflow)  ovf_cnt++;
      if (rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_val("sb_extra", {out_code, out_ascii, out_ext, out_brk}, 32'h3FFFF);
         end else begin
            check_val("event", {out_code, out_ascii, out_ext, out_brk}, sb_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b0; in_done = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", out_valid, 0);
      check_val("rst_shift", shift_o, 0);
      check_val("rst_caps", caps_o, 0);
      check_val("rst_err", err_frame, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_code", out_code, 0);
      rst = 1'b1;
      step();

      // latency of a plain make
      send(10'h21C);
      check_val("lat_c1", out_valid, 0);
      step();
      check_val("lat_c2", out_valid, 1);
      check_val("lat_code", out_code, 8'h1C);
      check_val("lat_ascii", out_ascii, 8'h61);
      exp_evt(8'h1C, 8'h61, 0, 0);
      drain();

      // shift held, letters and digit row, then release
      exp_evt(8'h12, 8'h00, 0, 0); send(10'h312);
      exp_evt(8'h1C, 8'h41, 0, 0); send(10'h21C);
      check_val("shift_on", shift_o, 1);
      exp_evt(8'h16, 8'h21, 0, 0); send(10'h216);
      send(10'h3F0);
`ifdef KBD_BREAK_EVENTS_EN
      exp_evt(8'h12, 8'h00, 0, 1);
`endif
      send(10'h312);
      step();
      check_val("shift_off", shift_o, 0);
      exp_evt(8'h16, 8'h31, 0, 0); send(10'h216);
      drain();

      // caps lock with typematic repeat
      exp_evt(8'h58, 8'h00, 0, 0); send(10'h258);
      exp_evt(8'h58, 8'h00, 0, 0); send(10'h258);
      step();
      check_val("caps_on", caps_o, 1);
      exp_evt(8'h1C, 8'h41, 0, 0); send(10'h21C);
      send(10'h3F0);
`ifdef KBD_BREAK_EVENTS_EN
      exp_evt(8'h58, 8'h00, 0, 1);
`endif
      send(10'h258);
      exp_evt(8'h58, 8'h00, 0, 0); send(10'h258);
      step();
      check_val("caps_off", caps_o, 0);
      exp_evt(8'h1C, 8'h61, 0, 0); send(10'h21C);
      exp_evt(8'h29, 8'h20, 0, 0); send(10'h229);
      drain();

      // extended make and extended break
      exp_evt(8'h75, 8'h00, 1, 0);
      send(10'h2E0); send(10'h275);
      send(10'h2E0); send(10'h3F0);
`ifdef KBD_BREAK_EVENTS_EN
      exp_evt(8'h75, 8'h00, 1, 1);
`endif
      send(10'h275);
      drain();

      // frame errors; a bad frame also clears a pending E0
      base = err_cnt;
      send(10'h31C);
      check_val("err_parity", err_frame, 1);
      send(10'h01C);
      check_val("err_stop", err_frame, 1);
      send(10'h2E0); send(10'h31C);
      exp_evt(8'h75, 8'h00, 0, 0); send(10'h275);
      drain();
      check_val("err_count", err_cnt - base, 3);

      // done held for several cycles counts once
      exp_evt(8'h1C, 8'h61, 0, 0);
      send(10'h21C, 4);
      drain();

      // overflow, then a push while full coincides with a pop
      out_ready = 1'b0;
      base = ovf_cnt;
      repeat (DEPTH + 1) send(10'h21C);
      step();
      check_val("ovf_count", ovf_cnt - base, 1);
      check_val("ovf_valid", out_valid, 1);
      send(10'h21C);
      out_ready = 1'b1;
      #1 check_val("full_pop_ovf", overflow, 0);
      repeat (DEPTH + 1) exp_evt(8'h1C, 8'h61, 0, 0);
      drain();
      check_val("ovf_after", ovf_cnt - base, 1);

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send(10'h21C);
      send(10'h2E0);
      step();
      rst = 1'b0;
      #1 check_val("rst_async", out_valid, 0);
      step();
      rst = 1'b1;
      exp_evt(8'h1C, 8'h61, 0, 0); send(10'h21C);
      step();
      check_val("rst_head_ext", out_ext, 0);
      drain();

      // plain break followed by a make
      send(10'h3F0);
`ifdef KBD_BREAK_EVENTS_EN
      exp_evt(8'h1C, 8'h61, 0, 1);
`endif
      send(10'h21C);
      exp_evt(8'h1C, 8'h61, 0, 0); send(10'h21C);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
